// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store per request, programmable wait states,
// byte/half/word access to an internal word RAM, errors acked instead of committed.
module dmem_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  output logic        ACKD_n,
  output logic        ERR
);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q;
  logic [1:0]    lane_q, size_q;
  logic          write_q, err_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   off;
  logic          oor, misal, accept;
  logic [3:0]    be;
  logic [31:0]   wdata_sh, rword, rdata;

  assign off    = DAD - ADDR_BASE;
  assign oor    = off >= 32'(4 * DEPTH_WORDS);
  assign accept = (state_q == S_IDLE) && MREQ;

  always_comb begin
    misal = 1'b0;
    case (SIZE)
      2'b00:   misal = off[1:0] != 2'b00;
      2'b01:   misal = off[0];
      2'b10:   misal = 1'b0;
      default: misal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= off[IW+1:2];
        lane_q  <= off[1:0];
        size_q  <= SIZE;
        write_q <= WRITE;
        err_q   <= oor | misal;
        wdata_q <= DDT;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ACKD_n  = 1'b1;
    ERR     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MREQ) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        // Dropping MREQ mid-wait abandons the access without an ack.
        if (!MREQ) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_ACK;
        end
      end
      S_ACK: begin
        ACKD_n  = 1'b0;
        ERR     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'b00:   be = 4'b1111;
      2'b01:   be = 4'b0011 << lane_q;
      2'b10:   be = 4'b0001 << lane_q;
      default: be = 4'b0000;
    endcase
  end

  assign wdata_sh = wdata_q << {lane_q, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_ACK && write_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx_q][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword = mem_q[idx_q] >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   rdata = rword;
      2'b01:   rdata = {16'h0, rword[15:0]};
      2'b10:   rdata = {24'h0, rword[7:0]};
      default: rdata = 32'h0;
    endcase
    if (err_q) rdata = 32'h0;
  end

  assign DDT = (state_q == S_ACK && !write_q) ? rdata : 32'bz;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (2 and 0 wait states) checked against a
// byte-array memory model under directed and random load/store traffic.
module tb_dmem_ctrl;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int DEPTH = 1024;
  localparam int WA = 2;
  localparam int WB = 0;

  logic        clk;
  logic        rst;
  logic [31:0] dad;
  logic        wr;
  logic [1:0]  sz;
  logic        drv_en;
  logic [31:0] drv_data;
  logic        mreq_a, mreq_b;
  wire  [31:0] ddt_a, ddt_b;
  logic        ackd_n_a, ackd_n_b, err_a, err_b;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mdl [2][64];

  assign ddt_a = drv_en ? drv_data : 32'bz;
  assign ddt_b = drv_en ? drv_data : 32'bz;

  dmem_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) u_dut_a (
    .clk(clk), .rst(rst), .DAD(dad), .DDT(ddt_a), .MREQ(mreq_a), .WRITE(wr),
    .SIZE(sz), .ACKD_n(ackd_n_a), .ERR(err_a)
  );

  dmem_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB)) u_dut_b (
    .clk(clk), .rst(rst), .DAD(dad), .DDT(ddt_b), .MREQ(mreq_b), .WRITE(wr),
    .SIZE(sz), .ACKD_n(ackd_n_b), .ERR(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic ack_of(input int inst);
    return (inst == 0) ? ackd_n_a : ackd_n_b;
  endfunction

  function automatic logic err_of(input int inst);
    return (inst == 0) ? err_a : err_b;
  endfunction

  function automatic logic [31:0] ddt_of(input int inst);
    return (inst == 0) ? ddt_a : ddt_b;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 4;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit exp_err(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] off;
    off = a - BASE;
    if (s == 2'b11) return 1'b1;
    if (off >= 32'(4 * DEPTH)) return 1'b1;
    if ((off % 32'(nbytes(s))) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input int inst, input logic [31:0] a, input logic [1:0] s);
    logic [31:0] off, v;
    off = a - BASE;
    v = 32'h0;
    for (int i = 0; i < nbytes(s); i++) v = v | ({24'h0, mdl[inst][off + 32'(i)]} << (8 * i));
    return v;
  endfunction

  function automatic void mdl_store(input int inst, input logic [31:0] a, input logic [1:0] s,
                                    input logic [31:0] d);
    logic [31:0] off;
    if (exp_err(a, s)) return;
    off = a - BASE;
    for (int i = 0; i < nbytes(s); i++) mdl[inst][off + 32'(i)] = d[8*i +: 8];
  endfunction

  // One complete access; optionally scrambles the bus while the request is in flight.
  task automatic tx(input int inst, input bit w, input logic [1:0] s, input logic [31:0] a,
                    input logic [31:0] d, input bit scr, output logic [31:0] rd);
    int wc;
    bit e;
    logic [31:0] exp_d;
    wc = (inst == 0) ? WA : WB;
    e = exp_err(a, s);
    exp_d = (w || e) ? 32'h0 : mdl_load(inst, a, s);
    rd = 32'h0;
    @(negedge clk);
    dad = a; wr = w; sz = s; drv_data = d; drv_en = w;
    if (inst == 0) mreq_a = 1'b1; else mreq_b = 1'b1;
    for (int k = 1; k <= wc + 1; k++) begin
      @(negedge clk);
      if (k <= wc) begin
        chk("ack_in_wait", 32'(ack_of(inst)), 32'd1);
      end else begin
        chk("ack", 32'(ack_of(inst)), 32'd0);
        chk("err", 32'(err_of(inst)), 32'(e));
        if (!w) begin
          rd = ddt_of(inst);
          chk("load_data", rd, exp_d);
        end
        mreq_a = 1'b0;
        mreq_b = 1'b0;
      end
      if (scr) begin
        dad = $urandom; sz = 2'($urandom); wr = 1'($urandom); drv_data = $urandom;
      end
    end
    if (w) mdl_store(inst, a, s, d);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int inst;
    rst = 1'b1; mreq_a = 1'b0; mreq_b = 1'b0; drv_en = 1'b0;
    dad = 32'h0; wr = 1'b0; sz = 2'b00; drv_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack_a", 32'(ackd_n_a), 32'd1);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_ack_b", 32'(ackd_n_b), 32'd1);
    chk("rst_err_b", 32'(err_b), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) tx(i, 1'b1, 2'b00, BASE + 32'(4 * w), $urandom, 1'b0, rd);

    tx(0, 1'b1, 2'b00, 32'h0001_0000, 32'hDEAD_BEEF, 1'b0, rd);
    tx(0, 1'b0, 2'b00, 32'h0001_0000, 32'h0, 1'b0, rd);
    chk("t1_word", rd, 32'hDEAD_BEEF);

    tx(0, 1'b1, 2'b10, 32'h0001_0001, 32'h0000_00AA, 1'b0, rd);
    tx(0, 1'b1, 2'b01, 32'h0001_0002, 32'h0000_1234, 1'b0, rd);
    tx(0, 1'b0, 2'b00, 32'h0001_0000, 32'h0, 1'b0, rd);
    chk("t2_word", rd, 32'h1234_AAEF);
    tx(0, 1'b0, 2'b10, 32'h0001_0003, 32'h0, 1'b0, rd);
    chk("t2_byte", rd, 32'h0000_0012);

    tx(0, 1'b0, 2'b00, 32'h0001_0002, 32'h0, 1'b0, rd);
    tx(0, 1'b1, 2'b01, 32'h0001_0001, 32'hFFFF_5555, 1'b0, rd);
    tx(0, 1'b1, 2'b11, 32'h0001_0000, 32'h0BAD_0BAD, 1'b0, rd);
    tx(0, 1'b0, 2'b11, 32'h0001_0000, 32'h0, 1'b0, rd);
    tx(0, 1'b1, 2'b00, BASE + 32'(4 * DEPTH), 32'hCAFE_F00D, 1'b0, rd);
    tx(0, 1'b1, 2'b00, 32'h0000_0000, 32'h7777_7777, 1'b0, rd);
    tx(0, 1'b0, 2'b00, 32'h0001_0000, 32'h0, 1'b0, rd);
    chk("t34_unchanged", rd, 32'h1234_AAEF);

    // Abort: MREQ drops during the wait phase.
    @(negedge clk);
    dad = 32'h0001_0008; wr = 1'b1; sz = 2'b00; drv_data = 32'h5A5A_5A5A; drv_en = 1'b1;
    mreq_a = 1'b1;
    @(negedge clk);
    chk("abort_wait", 32'(ackd_n_a), 32'd1);
    mreq_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ackd_n_a), 32'd1);
    end
    tx(0, 1'b0, 2'b00, 32'h0001_0008, 32'h0, 1'b0, rd);

    // Reset landing on the ack cycle of a store.
    @(negedge clk);
    dad = 32'h0001_000C; wr = 1'b1; sz = 2'b00; drv_data = 32'hA5A5_A5A5; drv_en = 1'b1;
    mreq_a = 1'b1;
    for (int k = 1; k <= WA + 1; k++) begin
      @(negedge clk);
      chk("rst_seq_ack", 32'(ackd_n_a), (k <= WA) ? 32'd1 : 32'd0);
    end
    rst = 1'b1; mreq_a = 1'b0;
    @(negedge clk);
    chk("rst_after_ack", 32'(ackd_n_a), 32'd1);
    chk("rst_after_err", 32'(err_a), 32'd0);
    rst = 1'b0;
    tx(0, 1'b0, 2'b00, 32'h0001_000C, 32'h0, 1'b0, rd);
    tx(0, 1'b1, 2'b00, 32'h0001_000C, 32'h1357_9BDF, 1'b0, rd);
    tx(0, 1'b0, 2'b00, 32'h0001_000C, 32'h0, 1'b0, rd);
    chk("rst_recover", rd, 32'h1357_9BDF);

    // Zero-wait back-to-back stores.
    @(negedge clk);
    dad = 32'h0001_0000; wr = 1'b1; sz = 2'b00; drv_data = 32'h1111_2222; drv_en = 1'b1;
    mreq_b = 1'b1;
    @(negedge clk);
    chk("b2b_ack1", 32'(ackd_n_b), 32'd0);
    dad = 32'h0001_0004; drv_data = 32'h3333_4444;
    @(negedge clk);
    chk("b2b_gap", 32'(ackd_n_b), 32'd1);
    @(negedge clk);
    chk("b2b_ack2", 32'(ackd_n_b), 32'd0);
    chk("b2b_err2", 32'(err_b), 32'd0);
    mreq_b = 1'b0;
    mdl_store(1, 32'h0001_0000, 2'b00, 32'h1111_2222);
    mdl_store(1, 32'h0001_0004, 2'b00, 32'h3333_4444);
    tx(1, 1'b0, 2'b00, 32'h0001_0000, 32'h0, 1'b0, rd);
    chk("b2b_word0", rd, 32'h1111_2222);
    tx(1, 1'b0, 2'b00, 32'h0001_0004, 32'h0, 1'b0, rd);
    chk("b2b_word1", rd, 32'h3333_4444);

    // Bus scrambled while in flight must not change the outcome.
    tx(0, 1'b1, 2'b01, 32'h0001_0006, 32'h0000_BEEF, 1'b1, rd);
    tx(0, 1'b0, 2'b00, 32'h0001_0004, 32'h0, 1'b1, rd);

    for (int n = 0; n < 400; n++) begin
      inst = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        a = BASE + 32'(4 * DEPTH) * 32'($urandom_range(1, 1000)) + 32'($urandom_range(0, 63));
      else
        a = BASE + 32'($urandom_range(0, 63));
      tx(inst, 1'($urandom), 2'($urandom), a, $urandom, 1'($urandom), rd);
    end

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) tx(i, 1'b0, 2'b00, BASE + 32'(4 * w), 32'h0, 1'b0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
